// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding and byte-count helpers.
// Imported by the interface, the holding register and the top level.
package alu_result_serializer_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  // The byte counter needs at least one bit, even when a result is a single byte.
  function automatic int cnt_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Handshake bundle between the ALU result register, the serializer and UART_TX.
// The master side is the surrounding system (ALU plus UART); the slave side is the serializer.
interface alu_result_serializer_if
  import alu_result_serializer_pkg::*;
#(
  parameter int Width = WIDTH_DEF
);
  logic [Width-1:0] ALU_OUT;
  logic             OUT_Valid;
  logic             TX_Busy;
  logic [7:0]       TX_P_DATA;
  logic             TX_D_VLD;

  modport master (
    output ALU_OUT, OUT_Valid, TX_Busy,
    input  TX_P_DATA, TX_D_VLD
  );

  modport slave (
    input  ALU_OUT, OUT_Valid, TX_Busy,
    output TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/alu_res_hold_reg.sv
// One-entry holding buffer for a pending ALU result while the shifter is still sending.
// A simultaneous read and write replaces the entry and leaves it full.
module alu_res_hold_reg
  import alu_result_serializer_pkg::*;
#(
  parameter int Width = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr,
  input  logic             rd,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic [Width-1:0] dout
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      full <= 1'b0;
    end else if (wr) begin
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

  // NOTE: the data word is qualified by 'full', so it carries no reset; only control state is reset.
  always_ff @(posedge CLK) begin
    if (wr) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes each valid ALU result LSB-byte-first onto the UART_TX parallel handshake,
// with a one-deep holding buffer so back-to-back results do not stall the ALU.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int Width = WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  alu_result_serializer_if.slave bus,
  input  logic                  ERR_Clr,
  output logic                  Busy,
  output logic                  Frame_Done,
  output logic                  OVR_Err
);

  localparam int NBYTES = nbytes(Width);
  localparam int CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  state_e           state;
  logic [Width-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       tx_data_q;
  logic             tx_vld_q;
  logic             frame_done_q;
  logic             ovr_err_q;

  logic             hold_full;
  logic [Width-1:0] hold_data;
  logic             hold_wr;
  logic             hold_rd;

  logic             idle;
  logic             last_done;
  logic             load_direct;
  logic             drop;
  logic [Width-1:0] load_word;
  logic [Width-1:0] next_shift;

  // NOTE: every signal in this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    idle        = (state == ST_IDLE);
    last_done   = (state == ST_DRAIN) && !bus.TX_Busy && (cnt_q == LAST_CNT);
    hold_rd     = hold_full && (idle || last_done);
    load_direct = idle && !hold_full && bus.OUT_Valid;
    // A held result always goes ahead of a newly arriving one.
    load_word   = hold_full ? hold_data : bus.ALU_OUT;
    next_shift  = shift_q >> 8;
    hold_wr     = bus.OUT_Valid && !load_direct && (!hold_full || hold_rd);
    drop        = bus.OUT_Valid && !load_direct && hold_full && !hold_rd;
  end

  alu_res_hold_reg #(.Width(Width)) u_hold (
    .CLK  (CLK),
    .RST  (RST),
    .wr   (hold_wr),
    .rd   (hold_rd),
    .din  (bus.ALU_OUT),
    .full (hold_full),
    .dout (hold_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold_rd || load_direct) begin
            shift_q   <= load_word;
            cnt_q     <= '0;
            tx_data_q <= load_word[7:0];
            tx_vld_q  <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.TX_Busy) begin
            tx_vld_q <= 1'b0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!bus.TX_Busy) begin
            if (cnt_q != LAST_CNT) begin
              cnt_q     <= cnt_q + CNT_W'(1);
              shift_q   <= next_shift;
              tx_data_q <= next_shift[7:0];
              tx_vld_q  <= 1'b1;
              state     <= ST_PRESENT;
            end else begin
              frame_done_q <= 1'b1;
              if (hold_full) begin
                shift_q   <= hold_data;
                cnt_q     <= '0;
                tx_data_q <= hold_data[7:0];
                tx_vld_q  <= 1'b1;
                state     <= ST_PRESENT;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ovr_err_q <= 1'b0;
    end else if (drop) begin
      ovr_err_q <= 1'b1;
    end else if (ERR_Clr) begin
      ovr_err_q <= 1'b0;
    end
  end

  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign Frame_Done    = frame_done_q;
  assign OVR_Err       = ovr_err_q;
  assign Busy          = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based
// reference model of accepted results, with the bench acting as the UART_TX responder.
module tb_alu_result_serializer;

  localparam int W  = 16;
  localparam int NB = W / 8;

  logic CLK = 1'b0;
  logic RST;
  logic ERR_Clr;
  logic Busy;
  logic Frame_Done;
  logic OVR_Err;

  alu_result_serializer_if #(.Width(W)) bus_if ();

  alu_result_serializer #(.Width(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus_if.slave),
    .ERR_Clr    (ERR_Clr),
    .Busy       (Busy),
    .Frame_Done (Frame_Done),
    .OVR_Err    (OVR_Err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: results still owed to the UART, and the byte stream they must produce.
  int         occ;
  logic [7:0] exp_q[$];
  logic       exp_fd;
  logic       exp_ovr;
  int         obs_fd;

  // UART_TX responder state.
  logic tx_busy;
  logic tx_busy_prev;
  int   tx_rem;
  int   byte_idx;
  logic last_taken;
  int   lat_min;
  int   lat_max;

  // Fires one extra result on the exact cycle the current frame completes.
  logic         edge_arm;
  logic [W-1:0] edge_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    occ          = 0;
    exp_q.delete();
    exp_fd       = 1'b0;
    exp_ovr      = 1'b0;
    tx_busy      = 1'b0;
    tx_busy_prev = 1'b0;
    tx_rem       = 0;
    byte_idx     = 0;
    last_taken   = 1'b0;
    edge_arm     = 1'b0;
  endtask

  // One clock: check outputs left by the previous edge, run the UART, update the model,
  // drive inputs for the next edge, then advance to the following negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic clr);
    logic         comp;
    logic         acc;
    logic         vv;
    logic [W-1:0] dd;
    logic [7:0]   want;

    check("frame_done", Frame_Done, exp_fd);
    check("busy", Busy, occ != 0);
    check("ovr_err", OVR_Err, exp_ovr);
    if (tx_busy_prev) check("dvld_drop", bus_if.TX_D_VLD, 1'b0);
    if (Frame_Done) obs_fd++;

    comp = 1'b0;
    if (tx_busy) begin
      tx_rem--;
      if (tx_rem == 0) begin
        tx_busy = 1'b0;
        if (last_taken) begin
          comp       = 1'b1;
          last_taken = 1'b0;
        end
      end
    end else if (bus_if.TX_D_VLD) begin
      check("byte_avail", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("tx_byte", bus_if.TX_P_DATA, want);
      end
      byte_idx++;
      if (byte_idx == NB) begin
        byte_idx   = 0;
        last_taken = 1'b1;
      end
      tx_busy = 1'b1;
      tx_rem  = $urandom_range(lat_max, lat_min);
    end
    tx_busy_prev = tx_busy;

    vv = v;
    dd = d;
    if (edge_arm && comp) begin
      vv       = 1'b1;
      dd       = edge_data;
      edge_arm = 1'b0;
    end
    // Capacity is two results (shifter + hold); a completing frame frees one slot this cycle.
    acc = vv && ((occ - int'(comp)) < 2);
    if (acc) begin
      for (int i = 0; i < NB; i++) exp_q.push_back(dd[8*i +: 8]);
    end
    if (vv && !acc) exp_ovr = 1'b1;
    else if (clr)   exp_ovr = 1'b0;
    occ    = occ - int'(comp) + int'(acc);
    exp_fd = comp;

    bus_if.OUT_Valid = vv;
    bus_if.ALU_OUT   = dd;
    ERR_Clr          = clr;
    bus_if.TX_Busy   = tx_busy;
    @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((occ != 0 || tx_busy) && n < budget) begin
      cycle(1'b0, W'($urandom), 1'b0);
      n++;
    end
    check("drain_timeout", n < budget, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("all_bytes_sent", exp_q.size(), 0);
  endtask

  task automatic apply_reset(input int n);
    RST              = 1'b0;
    bus_if.OUT_Valid = 1'b1;
    bus_if.ALU_OUT   = W'($urandom);
    ERR_Clr          = 1'($urandom);
    bus_if.TX_Busy   = 1'($urandom);
    repeat (n) @(negedge CLK);
    check("rst_dvld", bus_if.TX_D_VLD, 1'b0);
    check("rst_data", bus_if.TX_P_DATA, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_frame_done", Frame_Done, 1'b0);
    check("rst_ovr", OVR_Err, 1'b0);
    model_clear();
    RST              = 1'b1;
    bus_if.OUT_Valid = 1'b0;
    ERR_Clr          = 1'b0;
    bus_if.TX_Busy   = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_dvld", bus_if.TX_D_VLD, 1'b0);
      check("post_rst_busy", Busy, 1'b0);
    end
    bus_if.TX_Busy = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fd0;
    int n;
    RST              = 1'b0;
    ERR_Clr          = 1'b0;
    bus_if.OUT_Valid = 1'b0;
    bus_if.ALU_OUT   = '0;
    bus_if.TX_Busy   = 1'b0;
    obs_fd           = 0;
    lat_min          = 1;
    lat_max          = 1;
    model_clear();
    @(negedge CLK);

    // Reset with junk inputs, then release with TX_Busy high.
    apply_reset(2);

    // Single result with a slow UART.
    lat_min = 10; lat_max = 10;
    fd0 = obs_fd;
    cycle(1'b1, 16'hA55A, 1'b0);
    check("lat_dvld", bus_if.TX_D_VLD, 1'b1);
    check("lat_byte", bus_if.TX_P_DATA, 8'h5A);
    drain(200);
    check("single_frames", obs_fd - fd0, 1);
    check("single_busy_after", Busy, 1'b0);

    // Back-to-back results.
    lat_min = 3; lat_max = 3;
    fd0 = obs_fd;
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0);
    drain(200);
    check("b2b_frames", obs_fd - fd0, 2);
    check("b2b_ovr", OVR_Err, 1'b0);

    // Overrun, clear, then clear colliding with a new overrun.
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    cycle(1'b1, 16'h3333, 1'b0);
    drain(200);
    check("ovr_sticky", OVR_Err, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("ovr_cleared", OVR_Err, 1'b0);
    cycle(1'b1, 16'h4444, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0);
    cycle(1'b1, 16'h6666, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("ovr_set_wins", OVR_Err, 1'b1);
    drain(200);
    cycle(1'b0, '0, 1'b1);
    drain(50);

    // New result on the exact cycle the held result moves into the shifter.
    fd0 = obs_fd;
    cycle(1'b1, 16'hC001, 1'b0);
    cycle(1'b1, 16'hC002, 1'b0);
    edge_arm  = 1'b1;
    edge_data = 16'hC003;
    n = 0;
    while (edge_arm && n < 200) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    check("edge_fired", edge_arm, 1'b0);
    drain(200);
    check("edge_frames", obs_fd - fd0, 3);
    check("edge_ovr", OVR_Err, 1'b0);

    // Reset after the first byte of a frame, then a clean frame.
    lat_min = 5; lat_max = 5;
    cycle(1'b1, 16'hBEEF, 1'b0);
    n = 0;
    while (byte_idx != 1 && n < 100) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    check("midrst_first_byte", byte_idx, 1);
    cycle(1'b0, '0, 1'b0);
    apply_reset(2);
    fd0 = obs_fd;
    lat_min = 2; lat_max = 2;
    cycle(1'b1, 16'h00FF, 1'b0);
    drain(200);
    check("midrst_frames", obs_fd - fd0, 1);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 4) == 0, W'($urandom), ($urandom % 40) == 0);
    end
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
